// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and helpers for the two-port memory arbiter.
//            arb_state_t - arbiter FSM states
//            arb_grant_t - which requester owns the current access
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // The streak counter must be at least 3 bits wide and must be able to hold
  // STREAK_MAX itself.
  function automatic int streak_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : arb_timer
// Purpose  : Access watchdog for the memory arbiter. Counts cycles in which
//            enable is high; expired flags the cycle that would be the
//            TIMEOUT-th enabled cycle since the last clear.
// Ports    : clk, rst (async, active-high)
//            clear   - restart the count at zero
//            enable  - count this cycle (busy and no memory ack)
//            expired - this enabled cycle reaches TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Combinational so the arbiter can leave BUSY on the very cycle the limit
  // is reached, keeping mem_req_o high for exactly TIMEOUT cycles.
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates an instruction-fetch port and a data port onto one
//            memory bus. Data wins ties unless it has already taken
//            STREAK_MAX grants in a row while fetch waited. Each access is
//            watched by arb_timer; a timeout completes the access with
//            rdata 0 and sets the sticky err_o.
// Ports    : clk_i, rst_i (async, active-high)
//            i_*  - fetch requester (req/addr in, ack/rdata out)
//            d_*  - data requester (req/we/addr/wdata in, ack/rdata out)
//            mem_* - memory bus (req/we/addr/wdata out, ack/rdata in)
//            err_o - sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_ack_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
);

  localparam int SW = streak_width(STREAK_MAX);

  arb_state_t            state;
  arb_state_t            state_next;
  arb_grant_t            grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic [SW-1:0]         streak;
  logic                  err_q;

  logic                  busy;
  logic                  pick_d;
  logic                  done;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  timer_clear;
  logic                  timer_en;
  logic                  timer_expired;

  assign busy   = (state == BUSY_I) || (state == BUSY_D);
  // Data wins unless fetch is waiting and data has used up its streak.
  assign pick_d = d_req_i && (!i_req_i || (streak != SW'(STREAK_MAX)));
  // An ack on the timeout cycle still counts as a normal completion.
  assign done   = busy && (mem_ack_i || timer_expired);
  assign resp_data = (mem_ack_i && !we_q) ? mem_rdata_i : '0;

  assign timer_clear = (state == IDLE) && (state_next != IDLE);
  assign timer_en    = busy && !mem_ack_i;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_req_i || i_req_i) begin
          state_next = pick_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant     <= GRANT_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      streak    <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_next == BUSY_D)) begin
        grant   <= GRANT_D;
        addr_q  <= d_addr_i;
        we_q    <= d_we_i;
        wdata_q <= d_wdata_i;
        if (!i_req_i) begin
          streak <= '0;
        end else if (streak != SW'(STREAK_MAX)) begin
          streak <= streak + SW'(1);
        end
      end else if ((state == IDLE) && (state_next == BUSY_I)) begin
        grant   <= GRANT_I;
        addr_q  <= i_addr_i;
        we_q    <= 1'b0;
        wdata_q <= '0;
        streak  <= '0;
      end

      if (done) begin
        if (grant == GRANT_D) begin
          d_rdata_q <= resp_data;
        end else begin
          i_rdata_q <= resp_data;
        end
        if (!mem_ack_i) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign i_ack_o     = (state == RESP) && (grant == GRANT_I);
  assign d_ack_o     = (state == RESP) && (grant == GRANT_D);
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            streak_m;
  logic          err_m;
  logic [DW-1:0] i_rdata_m;
  logic [DW-1:0] d_rdata_m;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .STREAK_MAX (SMAX),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .i_req_i     (i_req),
    .i_addr_i    (i_addr),
    .i_ack_o     (i_ack_o),
    .i_rdata_o   (i_rdata_o),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .err_o       (err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    streak_m = 0; err_m = 1'b0; i_rdata_m = '0; d_rdata_m = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 32'h11; d_addr = 32'h22; d_wdata = 32'h33; mem_ack = 1'b1; mem_rdata = 32'h44;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if ({mem_req_o, mem_we_o, i_ack_o, d_ack_o, err_o} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl: got req/we/iack/dack/err=%b want 00000",
                 {mem_req_o, mem_we_o, i_ack_o, d_ack_o, err_o});
      end
      checks++;
      if ({mem_addr_o, mem_wdata_o, i_rdata_o, d_rdata_o} !== '0) begin
        errors++;
        $display("FAIL reset_data: got addr=%h wdata=%h irdata=%h drdata=%h want all 0",
                 mem_addr_o, mem_wdata_o, i_rdata_o, d_rdata_o);
      end
    end
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    i_req = 1'b1; i_addr = 32'h10;
    step();
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h10}) begin
        errors++;
        $display("FAIL fetch_bus c%0d: got req=%b we=%b addr=%h want 1 0 00000010",
                 c, mem_req_o, mem_we_o, mem_addr_o);
      end
      mem_ack = (c == 2); mem_rdata = 32'hDEADBEEF;
      step();
      mem_ack = 1'b0;
    end
    checks++;
    if ({i_ack_o, d_ack_o, i_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL fetch_resp: got iack=%b dack=%b irdata=%h want 1 0 deadbeef",
               i_ack_o, d_ack_o, i_rdata_o);
    end
    i_req = 1'b0;
    step();
    checks++;
    if ({i_ack_o, mem_req_o, i_rdata_o} !== {2'b00, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL fetch_after: got iack=%b req=%b irdata=%h want 0 0 deadbeef",
               i_ack_o, mem_req_o, i_rdata_o);
    end
  endtask

  task automatic test_streak();
    bit exp_d;
    do_reset();
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
    for (int g = 0; g < 11; g++) begin
      exp_d = ((g % 5) != 4);   // D,D,D,D,I repeating
      step();
      checks++;
      if (exp_d && ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h40, 32'h55})) begin
        errors++;
        $display("FAIL streak_d g%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 40 55",
                 g, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end else if (!exp_d && ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h80})) begin
        errors++;
        $display("FAIL streak_i g%0d: got req=%b we=%b addr=%h want 1 0 80",
                 g, mem_req_o, mem_we_o, mem_addr_o);
      end
      mem_ack = 1'b1; mem_rdata = 32'h0BAD0000 + g;
      step();
      mem_ack = 1'b0;
      checks++;
      if ({d_ack_o, i_ack_o} !== {exp_d, !exp_d}) begin
        errors++;
        $display("FAIL streak_ack g%0d: got dack=%b iack=%b want %b %b",
                 g, d_ack_o, i_ack_o, exp_d, !exp_d);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    step();
    n = 0;
    while (mem_req_o === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL timeout_len: got %0d busy cycles want %0d", n, TMO);
    end
    checks++;
    if ({d_ack_o, i_ack_o, err_o, d_rdata_o} !== {3'b101, 32'h0}) begin
      errors++;
      $display("FAIL timeout_resp: got dack=%b iack=%b err=%b drdata=%h want 1 0 1 0",
               d_ack_o, i_ack_o, err_o, d_rdata_o);
    end
    d_req = 1'b0;
    step();
    checks++;
    if ({d_ack_o, err_o} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_sticky: got dack=%b err=%b want 0 1", d_ack_o, err_o);
    end
    i_req = 1'b1; i_addr = 32'h30;
    step();
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h30}) begin
      errors++;
      $display("FAIL timeout_next_bus: got req=%b addr=%h want 1 30", mem_req_o, mem_addr_o);
    end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0; i_req = 1'b0;
    checks++;
    if ({i_ack_o, err_o, i_rdata_o} !== {2'b11, 32'h12345678}) begin
      errors++;
      $display("FAIL timeout_next_resp: got iack=%b err=%b irdata=%h want 1 1 12345678",
               i_ack_o, err_o, i_rdata_o);
    end
    step();
  endtask

  // Runs straight after test_timeout so err_o starts at 1.
  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    step();
    step();
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got req=%b want 1", mem_req_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, d_ack_o, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_async: got req=%b dack=%b err=%b want 000", mem_req_o, d_ack_o, err_o);
    end
    d_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if ({mem_req_o, d_ack_o, i_ack_o, err_o} !== 4'b0) begin
        errors++;
        $display("FAIL rstmid_noack n%0d: got req=%b dack=%b iack=%b err=%b want 0000",
                 n, mem_req_o, d_ack_o, i_ack_o, err_o);
      end
    end
    rst = 1'b1; d_req = 1'b1; d_addr = 32'h48;
    #3 rst = 1'b0;
    step();
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h48}) begin
      errors++;
      $display("FAIL first_grant: got req=%b addr=%h want 1 48", mem_req_o, mem_addr_o);
    end
    mem_ack = 1'b1; mem_rdata = 32'h77;
    step();
    mem_ack = 1'b0; d_req = 1'b0;
    checks++;
    if ({d_ack_o, d_rdata_o} !== {1'b1, 32'h77}) begin
      errors++;
      $display("FAIL first_resp: got dack=%b drdata=%h want 1 77", d_ack_o, d_rdata_o);
    end
    step();
  endtask

  task automatic test_spurious();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      mem_ack = 1'b1; mem_rdata = 32'hFFFF0000 + n;
      step();
      checks++;
      if ({mem_req_o, i_ack_o, d_ack_o, i_rdata_o, d_rdata_o} !== '0) begin
        errors++;
        $display("FAIL spurious n%0d: got req=%b iack=%b dack=%b irdata=%h drdata=%h want all 0",
                 n, mem_req_o, i_ack_o, d_ack_o, i_rdata_o, d_rdata_o);
      end
    end
    mem_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    step();
    for (int c = 1; c <= TMO; c++) begin
      checks++;
      if (mem_req_o !== 1'b1) begin
        errors++;
        $display("FAIL edge_ack_busy c%0d: got req=%b want 1", c, mem_req_o);
      end
      mem_ack = (c == TMO); mem_rdata = 32'hCAFEF00D;
      step();
      mem_ack = 1'b0;
    end
    d_req = 1'b0;
    checks++;
    if ({d_ack_o, err_o, d_rdata_o} !== {2'b10, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL edge_ack_resp: got dack=%b err=%b drdata=%h want 1 0 cafef00d",
               d_ack_o, err_o, d_rdata_o);
    end
    step();
  endtask

  task automatic test_random();
    logic          pi, pd, dwe, ewe, win_d;
    logic [AW-1:0] ia, da, ea;
    logic [DW-1:0] dwd, ew, rd, exp_rd;
    int            lat, done_cnt;
    do_reset();
    pi = 1'b0; pd = 1'b0; dwe = 1'b0; ia = '0; da = '0; dwd = '0; rd = '0;
    done_cnt = 0;
    for (int it = 0; it < 400 && done_cnt < 60; it++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1'b1; ia = $urandom;
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1'b1; da = $urandom; dwd = $urandom; dwe = 1'($urandom_range(0, 1));
      end
      i_req = pi; i_addr = ia; d_req = pd; d_addr = da; d_we = dwe; d_wdata = dwd;
      mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = $urandom;
      if (!pi && !pd) begin
        step();
        checks++;
        if ({mem_req_o, i_ack_o, d_ack_o} !== 3'b000) begin
          errors++;
          $display("FAIL rnd_idle it%0d: got req=%b iack=%b dack=%b want 000",
                   it, mem_req_o, i_ack_o, d_ack_o);
        end
        continue;
      end
      // Reference arbitration decision
      win_d = pd && (!pi || streak_m != SMAX);
      if (win_d) streak_m = pi ? ((streak_m < SMAX) ? streak_m + 1 : SMAX) : 0;
      else       streak_m = 0;
      ea  = win_d ? da : ia;
      ewe = win_d ? dwe : 1'b0;
      ew  = dwd;
      lat = $urandom_range(1, 20);
      step();
      for (int c = 1; c <= TMO; c++) begin
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, ewe, ea}) begin
          errors++;
          $display("FAIL rnd_bus it%0d c%0d: got req=%b we=%b addr=%h want 1 %b %h",
                   it, c, mem_req_o, mem_we_o, mem_addr_o, ewe, ea);
        end
        if (ewe) begin
          checks++;
          if (mem_wdata_o !== ew) begin
            errors++;
            $display("FAIL rnd_wdata it%0d c%0d: got %h want %h", it, c, mem_wdata_o, ew);
          end
        end
        mem_ack = (c == lat); rd = $urandom; mem_rdata = rd;
        if ($urandom_range(0, 7) == 0) begin
          if (win_d) d_req = 1'b0;
          else       i_req = 1'b0;
        end
        step();
        mem_ack = 1'b0;
        if (c == lat) break;
      end
      if (lat <= TMO) begin
        exp_rd = ewe ? '0 : rd;
      end else begin
        exp_rd = '0;
        err_m  = 1'b1;
      end
      if (win_d) d_rdata_m = exp_rd;
      else       i_rdata_m = exp_rd;
      checks++;
      if ({i_ack_o, d_ack_o, mem_req_o, err_o} !== {!win_d, win_d, 1'b0, err_m}) begin
        errors++;
        $display("FAIL rnd_resp it%0d: got iack=%b dack=%b req=%b err=%b want %b %b 0 %b",
                 it, i_ack_o, d_ack_o, mem_req_o, err_o, !win_d, win_d, err_m);
      end
      checks++;
      if ({i_rdata_o, d_rdata_o} !== {i_rdata_m, d_rdata_m}) begin
        errors++;
        $display("FAIL rnd_rdata it%0d: got irdata=%h drdata=%h want %h %h",
                 it, i_rdata_o, d_rdata_o, i_rdata_m, d_rdata_m);
      end
      if (win_d) pd = 1'b0;
      else       pi = 1'b0;
      i_req = pi; d_req = pd;
      step();
      checks++;
      if ({i_ack_o, d_ack_o} !== 2'b00) begin
        errors++;
        $display("FAIL rnd_ackpulse it%0d: got iack=%b dack=%b want 00", it, i_ack_o, d_ack_o);
      end
      done_cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_streak();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; STREAK_MAX, 4, max consecutive data grants while fetch waits; TIMEOUT, 16, cycles allowed for mem_ack_i.
REQ-002 Ports SHALL be: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-003 Fetch port SHALL be: i_req_i in 1 fetch request; i_addr_i in ADDR_WIDTH fetch address; i_ack_o out 1 fetch done pulse; i_rdata_o out DATA_WIDTH fetched word.
REQ-004 Data port SHALL be: d_req_i in 1; d_we_i in 1 write enable; d_addr_i in ADDR_WIDTH; d_wdata_i in DATA_WIDTH; d_ack_o out 1; d_rdata_o out DATA_WIDTH.
REQ-005 Memory side SHALL be: mem_req_o out 1; mem_we_o out 1; mem_addr_o out ADDR_WIDTH; mem_wdata_o out DATA_WIDTH; mem_ack_i in 1; mem_rdata_i in DATA_WIDTH.
REQ-006 Status SHALL be: err_o out 1, sticky timeout flag.

Function
REQ-007 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP.
REQ-008 IDLE: d_req_i only -> BUSY_D; i_req_i only -> BUSY_I; both -> BUSY_D unless streak==STREAK_MAX, then BUSY_I; neither -> IDLE.
REQ-009 On entering BUSY_x, arbiter SHALL register the winner's address, we and wdata; mem_* outputs drive these registered values, stable for the whole BUSY state.
REQ-010 mem_req_o SHALL be 1 exactly in BUSY_I/BUSY_D; mem_we_o SHALL be 0 in BUSY_I.
REQ-011 BUSY_x with mem_ack_i=1 SHALL capture mem_rdata_i (0 for writes) into x_rdata_o and go to RESP.
REQ-012 RESP SHALL pulse the granted port's ack for exactly one cycle, then go to IDLE; other ack SHALL stay 0.
REQ-013 Latency: request seen in IDLE at cycle 0, mem_ack_i at cycle k>=1 -> ack_o high at cycle k+1; minimum 3 cycles request-to-ack.
REQ-014 x_rdata_o SHALL hold its value until the next completion on that port.
REQ-015 Requesters SHALL hold req, addr, we, wdata until ack; a req dropped during BUSY SHALL NOT abort the access; ack is still pulsed.
REQ-016 Streak counter (3 bits min): increments on data grant while i_req_i=1, saturates at STREAK_MAX; clears on fetch grant or on data grant with i_req_i=0.
REQ-017 Timeout counter SHALL clear on entering BUSY_x and increment each BUSY cycle without mem_ack_i; at TIMEOUT, set err_o, drop mem_req_o, go to RESP with rdata 0.
REQ-018 mem_ack_i SHALL be ignored in IDLE and RESP; mem_ack_i on the same cycle as timeout SHALL count as a normal completion, err_o unchanged.
REQ-019 err_o SHALL remain 1 until reset; arbitration continues normally after an error.

Reset
REQ-020 rst_i SHALL immediately force IDLE, clear streak, timeout and err_o, and drive all outputs to 0, including mid-access; no ack is issued for an interrupted access.
REQ-021 The first grant SHALL be possible on the first rising edge after rst_i deasserts.

Structure
REQ-022 The state enum (arb_state_t) and grant type (arb_grant_t: GRANT_I, GRANT_D) SHALL be defined in a shared package mem_arb_pkg.
REQ-023 The timeout counter SHALL be a sub-module arb_timer (clear, enable, expired); all other logic stays in mem_arbiter.

Verification
REQ-024 Scenario: i_req_i=1, addr 0x10; memory acks 2 cycles after mem_req_o with 0xDEADBEEF -> i_ack_o 1 cycle, i_rdata_o=0xDEADBEEF, mem_we_o=0 throughout.
REQ-025 Scenario: i_req_i and d_req_i both held continuously, d_we_i=1, d_addr_i 0x40, d_wdata_i 0x55 -> grant order D,D,D,D,I,D,...; mem_wdata_o=0x55 on every D access.
REQ-026 Scenario: d_req_i read, mem_ack_i never asserted -> mem_req_o drops after 16 cycles, d_ack_o pulses with d_rdata_o=0, err_o=1 and stays 1; next fetch completes normally.
REQ-027 Scenario: rst_i asserted during BUSY_D -> mem_req_o=0 and state IDLE the same cycle; no d_ack_o; err_o=0.
REQ-028 Scenario: spurious mem_ack_i in IDLE with no requests -> no ack outputs, no state change; mem_ack_i on the timeout cycle -> normal completion, err_o=0.
